// File: rtl/mul_share_arbiter.sv
// Round-robin sharing of one pipelined 32x32 low-word multiplier cell among NUM_REQ requesters.
// Define MUL_ARB_PERF_EN to build the issue/stall performance counters; otherwise they read 0.
module mul_share_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int MUL_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*32-1:0] req_src1,
  input  logic [NUM_REQ*32-1:0] req_src2,
  output logic [NUM_REQ-1:0]    rsp_valid,
  input  logic [NUM_REQ-1:0]    rsp_ready,
  output logic [NUM_REQ*32-1:0] rsp_result,
  output logic [31:0]           mul_src1,
  output logic [31:0]           mul_src2,
  input  logic [31:0]           mul_result,
  output logic                  busy,
  output logic [31:0]           perf_issue_cnt,
  output logic [31:0]           perf_stall_cnt
);

  localparam int IDW   = $clog2(NUM_REQ);
  localparam int DEPTH = MUL_LATENCY + 1;

  logic [IDW-1:0]     ptr_reg;
  logic [IDW-1:0]     ptr_next;
  logic [DEPTH-1:0]   fl_valid_reg;
  logic [IDW-1:0]     fl_id_reg [DEPTH];
  logic [31:0]        mul_src1_reg;
  logic [31:0]        mul_src2_reg;

  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] slot_valid;
  logic               grant_found;
  logic [IDW-1:0]     grant_id;
  logic               issue;
  logic [31:0]        src1_sel;
  logic [31:0]        src2_sel;
  logic               capture;
  logic [IDW-1:0]     capture_id;

  // The tail of the tracking pipe lines up with mul_result for the op it names.
  assign capture    = fl_valid_reg[DEPTH-1];
  assign capture_id = fl_id_reg[DEPTH-1];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      logic        hit;
      logic        slot_valid_reg;
      logic [31:0] slot_data_reg;

      always_comb begin
        hit = 1'b0;
        for (int d = 0; d < DEPTH; d++) begin
          if (fl_valid_reg[d] && (fl_id_reg[d] == IDW'(gi))) begin
            hit = 1'b1;
          end
        end
      end

      assign eligible[gi] = req_valid[gi] & ~slot_valid_reg & ~hit;

      // Capture and acceptance cannot coincide: one outstanding op per requester.
      always_ff @(posedge clk) begin
        if (reset) begin
          slot_valid_reg <= 1'b0;
          slot_data_reg  <= '0;
        end else if (capture && (capture_id == IDW'(gi))) begin
          slot_valid_reg <= 1'b1;
          slot_data_reg  <= mul_result;
        end else if (slot_valid_reg && rsp_ready[gi]) begin
          slot_valid_reg <= 1'b0;
        end
      end

      assign slot_valid[gi]            = slot_valid_reg;
      assign rsp_result[gi*32 +: 32]   = slot_data_reg;
    end
  endgenerate

  // Search upward from the pointer, wrapping at NUM_REQ (which need not be a power of two).
  always_comb begin
    logic [IDW:0] idx;
    grant_found = 1'b0;
    grant_id    = '0;
    idx         = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, ptr_reg} + (IDW+1)'(k);
      if (idx >= (IDW+1)'(NUM_REQ)) begin
        idx = idx - (IDW+1)'(NUM_REQ);
      end
      if (!grant_found && eligible[idx[IDW-1:0]]) begin
        grant_found = 1'b1;
        grant_id    = idx[IDW-1:0];
      end
    end
    if (reset) begin
      grant_found = 1'b0;
    end
  end

  assign issue     = grant_found;
  assign req_ready = grant_found ? (NUM_REQ'(1) << grant_id) : '0;

  always_comb begin
    ptr_next = ptr_reg;
    if (grant_found) begin
      ptr_next = (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
    end
  end

  always_comb begin
    src1_sel = '0;
    src2_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == IDW'(i)) begin
        src1_sel = req_src1[i*32 +: 32];
        src2_sel = req_src2[i*32 +: 32];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_reg      <= '0;
      mul_src1_reg <= '0;
      mul_src2_reg <= '0;
      fl_valid_reg <= '0;
      for (int d = 0; d < DEPTH; d++) begin
        fl_id_reg[d] <= '0;
      end
    end else begin
      ptr_reg <= ptr_next;
      if (issue) begin
        mul_src1_reg <= src1_sel;
        mul_src2_reg <= src2_sel;
      end
      fl_valid_reg <= {fl_valid_reg[DEPTH-2:0], issue};
      fl_id_reg[0] <= grant_id;
      for (int d = 1; d < DEPTH; d++) begin
        fl_id_reg[d] <= fl_id_reg[d-1];
      end
    end
  end

  assign mul_src1  = mul_src1_reg;
  assign mul_src2  = mul_src2_reg;
  assign rsp_valid = slot_valid;
  assign busy      = (|fl_valid_reg) | (|slot_valid);

`ifdef MUL_ARB_PERF_EN
  logic [31:0] perf_issue_reg;
  logic [31:0] perf_stall_reg;
  logic        stall_cycle;

  // Contention (two or more eligible) or a pending request that could not be granted.
  assign stall_cycle = ((|req_valid) & ~grant_found) |
                       ((eligible & (eligible - NUM_REQ'(1))) != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_issue_reg <= '0;
      perf_stall_reg <= '0;
    end else begin
      if (issue) begin
        perf_issue_reg <= perf_issue_reg + 32'd1;
      end
      if (stall_cycle) begin
        perf_stall_reg <= perf_stall_reg + 32'd1;
      end
    end
  end

  assign perf_issue_cnt = perf_issue_reg;
  assign perf_stall_cnt = perf_stall_reg;
`else
  assign perf_issue_cnt = '0;
  assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Randomized bench for mul_share_arbiter against a cycle-level transaction model
// (per-requester outstanding op with due cycle, result slot, round-robin pointer).
module tb_mul_share_arbiter;

  localparam int N = 4;
  localparam int L = 1;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*32-1:0] req_src1;
  logic [N*32-1:0] req_src2;
  logic [N-1:0]    rsp_valid;
  logic [N-1:0]    rsp_ready;
  logic [N*32-1:0] rsp_result;
  logic [31:0]     mul_src1;
  logic [31:0]     mul_src2;
  logic [31:0]     mul_result;
  logic            busy;
  logic [31:0]     perf_issue_cnt;
  logic [31:0]     perf_stall_cnt;

  mul_share_arbiter #(.NUM_REQ(N), .MUL_LATENCY(L)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_src1(req_src1), .req_src2(req_src2),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .mul_src1(mul_src1), .mul_src2(mul_src2), .mul_result(mul_result),
    .busy(busy), .perf_issue_cnt(perf_issue_cnt), .perf_stall_cnt(perf_stall_cnt)
  );

  always #5 clk = ~clk;

  // Multiplier cell: L register stages after the operand registers.
  logic [31:0] cell_pipe [L];
  always @(posedge clk) begin
    cell_pipe[0] <= mul_src1 * mul_src2;
    for (int k = 1; k < L; k++) cell_pipe[k] <= cell_pipe[k-1];
  end
  assign mul_result = cell_pipe[L-1];

  logic [N-1:0] drv_valid;
  logic [N-1:0] drv_ready;
  logic [31:0]  drv_a [N];
  logic [31:0]  drv_b [N];

  assign req_valid = drv_valid;
  assign rsp_ready = drv_ready;
  always_comb begin
    req_src1 = '0;
    req_src2 = '0;
    for (int i = 0; i < N; i++) begin
      req_src1[i*32 +: 32] = drv_a[i];
      req_src2[i*32 +: 32] = drv_b[i];
    end
  end

  // Reference model state
  int          m_ptr;
  bit          m_out  [N];
  int          m_due  [N];
  logic [31:0] m_prod [N];
  bit          m_slot [N];
  logic [31:0] m_data [N];
  logic [31:0] m_src1, m_src2, m_issue, m_stall;
  int          cyc;
  int          last_gnt;
  bit          chk_en;
  int          checks;
  int          errors;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 4))
      0:       return 32'hFFFF_FFFF;
      1:       return 32'h8000_0000;
      2:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic model_clear();
    m_ptr = 0; m_src1 = '0; m_src2 = '0; m_issue = '0; m_stall = '0;
    for (int i = 0; i < N; i++) begin
      m_out[i] = 0; m_slot[i] = 0; m_due[i] = 0; m_prod[i] = '0; m_data[i] = '0;
    end
  endtask

  // One clock cycle: called just after a posedge with drivers already set.
  task automatic cycle(input bit rst);
    logic [N-1:0] elig, exp_ready, exp_rsp;
    bit any_busy;
    int gnt, idx, n_elig;
    for (int i = 0; i < N; i++) begin
      if (m_out[i] && m_due[i] == cyc) begin
        m_slot[i] = 1; m_data[i] = m_prod[i]; m_out[i] = 0;
      end
    end
    reset = rst;
    @(negedge clk);
    elig = '0; exp_rsp = '0; any_busy = 0; n_elig = 0;
    for (int i = 0; i < N; i++) begin
      elig[i]    = drv_valid[i] && !m_slot[i] && !m_out[i];
      exp_rsp[i] = m_slot[i];
      if (m_slot[i] || m_out[i]) any_busy = 1;
      if (elig[i]) n_elig++;
    end
    gnt = -1;
    if (!rst) begin
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (gnt < 0 && elig[idx]) gnt = idx;
      end
    end
    exp_ready = (gnt >= 0) ? N'(1) << gnt : '0;
    if (chk_en) begin
      check_val("req_ready", 32'(req_ready), 32'(exp_ready));
      check_val("rsp_valid", 32'(rsp_valid), 32'(exp_rsp));
      check_val("busy", 32'(busy), 32'(any_busy));
      check_val("mul_src1", mul_src1, m_src1);
      check_val("mul_src2", mul_src2, m_src2);
      for (int i = 0; i < N; i++)
        if (m_slot[i]) check_val($sformatf("rsp_result%0d", i), rsp_result[i*32 +: 32], m_data[i]);
`ifdef MUL_ARB_PERF_EN
      check_val("perf_issue", perf_issue_cnt, m_issue);
      check_val("perf_stall", perf_stall_cnt, m_stall);
`else
      check_val("perf_issue", perf_issue_cnt, 32'd0);
      check_val("perf_stall", perf_stall_cnt, 32'd0);
`endif
    end
    @(posedge clk);
    if (rst) begin
      model_clear();
    end else begin
      if (n_elig > 1 || (drv_valid != '0 && gnt < 0)) m_stall = m_stall + 1;
      for (int i = 0; i < N; i++)
        if (m_slot[i] && drv_ready[i]) m_slot[i] = 0;
      if (gnt >= 0) begin
        m_issue     = m_issue + 1;
        m_src1      = drv_a[gnt];
        m_src2      = drv_b[gnt];
        m_out[gnt]  = 1;
        m_due[gnt]  = cyc + 2 + L;
        m_prod[gnt] = 32'(64'(drv_a[gnt]) * 64'(drv_b[gnt]));
        m_ptr       = (gnt + 1) % N;
      end
    end
    last_gnt = gnt;
    $display("cyc=%0d rst=%0b valid=%b ready=%b grant=%0d rsp_valid=%b",
             cyc, rst, drv_valid, drv_ready, gnt, exp_rsp);
    cyc++;
    #1;
  endtask

  // Granted requesters drop valid and get fresh operands; optionally raise new requests.
  task automatic step(input bit rst, input bit refill);
    cycle(rst);
    if (last_gnt >= 0) begin
      drv_valid[last_gnt] = 1'b0;
      drv_a[last_gnt] = pick_val();
      drv_b[last_gnt] = pick_val();
    end
    if (refill)
      for (int i = 0; i < N; i++)
        if (!drv_valid[i] && $urandom_range(0, 2) == 0) drv_valid[i] = 1'b1;
  endtask

  task automatic one_op(input int r, input logic [31:0] a, input logic [31:0] b);
    drv_a[r] = a; drv_b[r] = b; drv_valid[r] = 1'b1;
    for (int k = 0; k < L + 5; k++) step(0, 0);
  endtask

  logic [31:0] wa [3];
  logic [31:0] wb [3];

  initial begin
    checks = 0; errors = 0; cyc = 0; chk_en = 0; last_gnt = -1;
    model_clear();
    drv_valid = '1; drv_ready = '1;
    for (int i = 0; i < N; i++) begin drv_a[i] = 32'(i + 1); drv_b[i] = 32'(i + 7); end
    reset = 1'b1;

    // Reset held 2 cycles with all requests valid, then requester 0 wins first.
    cycle(1);
    chk_en = 1;
    cycle(1);
    step(0, 0);
    drv_valid = '0;
    for (int k = 0; k < 4; k++) step(0, 0);

    // Single op on requester 1, then the wrap-around products on requester 3 (pointer ends at 0).
    one_op(1, 32'd3, 32'd5);
    wa[0] = 32'hFFFF_FFFF; wb[0] = 32'hFFFF_FFFF;
    wa[1] = 32'h0001_2345; wb[1] = 32'h0001_0000;
    wa[2] = 32'h8000_0000; wb[2] = 32'd2;
    for (int j = 0; j < 3; j++) one_op(3, wa[j], wb[j]);

    // Contention from a clean reset so the perf counters are scenario-local.
    step(1, 0);
    drv_valid = '1;
    for (int k = 0; k < 10; k++) step(0, 0);

    // Backpressure on requester 2 with its request held high.
    drv_ready = 4'b1011;
    drv_valid[2] = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step(0, 1);
      drv_valid[2] = 1'b1;
    end
    drv_ready = '1;
    step(0, 0);
    drv_ready = 4'b1011;
    drv_valid[2] = 1'b1;
    for (int k = 0; k < 3; k++) step(0, 0);
    drv_ready = '1;
    drv_valid = '0;
    for (int k = 0; k < 6; k++) step(0, 0);

    // Reset one cycle after an issue: the result must never surface.
    drv_valid[0] = 1'b1;
    step(0, 0);
    step(1, 0);
    for (int k = 0; k < 5; k++) step(0, 0);

    // Randomized traffic with random backpressure and rare resets.
    for (int k = 0; k < 600; k++) begin
      drv_ready = N'($urandom);
      step(($urandom_range(0, 149) == 0), 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
